// File: rtl/hsv_to_rgb_pipe.sv
// hsv_to_rgb_pipe: three-stage streaming HSV to RGB565/RGB888 converter with valid/ready and sideband tag
module hsv_to_rgb_pipe #(
   parameter int OUT_MODE = 0,
   parameter int USER_W   = 1,
   parameter int HUE_MAX  = 359
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [8:0]        in_h,
   input  logic [7:0]        in_s,
   input  logic [7:0]        in_v,
   input  logic [USER_W-1:0] in_user,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [23:0]       out_rgb,
   output logic [USER_W-1:0] out_user
);
   localparam logic [8:0] HMAX = 9'(HUE_MAX);
   logic              adv;
   logic              vld1, vld2;
   logic [7:0]        s1, v1, rem1;
   logic [2:0]        reg1;
   logic [USER_W-1:0] user1, user2;
   logic [7:0]        r2, g2, b2;
   logic [8:0]        hc;
   logic [16:0]       hue_prod;
   logic [7:0]        nh, rem;
   logic [2:0]        region;
   logic [7:0]        p, q, t, r, g, b;
   logic [23:0]       rgb_d;
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;
   // S1: saturate hue, scale to 0..254 and split into sector and position within sector
   always_comb begin
      hc       = (in_h > HMAX) ? HMAX : in_h;
      hue_prod = 17'(hc) * 17'd255;
      nh       = 8'(hue_prod / 17'd360);
      region   = 3'(nh / 8'd43);
      rem      = 8'((nh - 8'(region) * 8'd43) * 8'd6);
   end
   // S2: full-width products, then per-sector channel selection; zero saturation forces grey
   always_comb begin
      p = 8'((16'(v1) * 16'(8'd255 - s1)) >> 8);
      q = 8'((16'(v1) * 16'(8'd255 - 8'((16'(s1) * 16'(rem1)) >> 8))) >> 8);
      t = 8'((16'(v1) * 16'(8'd255 - 8'((16'(s1) * 16'(8'd255 - rem1)) >> 8))) >> 8);
      case (reg1)
         3'd0:    {r, g, b} = {v1, t, p};
         3'd1:    {r, g, b} = {q, v1, p};
         3'd2:    {r, g, b} = {p, v1, t};
         3'd3:    {r, g, b} = {p, q, v1};
         3'd4:    {r, g, b} = {t, p, v1};
         default: {r, g, b} = {v1, p, q};
      endcase
      if (s1 == 8'd0) {r, g, b} = {v1, v1, v1};
   end
   // S3: pack into the selected output format
   always_comb begin
      rgb_d = (OUT_MODE == 1) ? {r2, g2, b2} :
              {8'h00, 5'((16'(r2) * 16'd31) / 16'd255), 6'((16'(g2) * 16'd63) / 16'd255),
               5'((16'(b2) * 16'd31) / 16'd255)};
   end
   // pipeline registers: every stage loads together on adv and holds together otherwise
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld1      <= 1'b0;
         s1        <= '0;
         v1        <= '0;
         reg1      <= '0;
         rem1      <= '0;
         user1     <= '0;
         vld2      <= 1'b0;
         r2        <= '0;
         g2        <= '0;
         b2        <= '0;
         user2     <= '0;
         out_valid <= 1'b0;
         out_rgb   <= '0;
         out_user  <= '0;
      end else if (adv) begin
         vld1      <= in_valid;
         s1        <= in_s;
         v1        <= in_v;
         reg1      <= region;
         rem1      <= rem;
         user1     <= in_user;
         vld2      <= vld1;
         r2        <= r;
         g2        <= g;
         b2        <= b;
         user2     <= user1;
         out_valid <= vld2;
         out_rgb   <= rgb_d;
         out_user  <= user2;
      end
   end
endmodule

// File: tb/tb_hsv_to_rgb_pipe.sv
// tb_hsv_to_rgb_pipe: directed and randomised checks of both output formats
module tb_hsv_to_rgb_pipe;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [8:0]  in_h = '0;
   logic [7:0]  in_s = '0, in_v = '0;
   logic [3:0]  in_user = '0;
   logic        rdy0, rdy1, ov0, ov1;
   logic [23:0] rgb0, rgb1;
   logic [3:0]  ou0, ou1;
   int          n_checks = 0, n_fail = 0;

   always #5 clk = ~clk;

   hsv_to_rgb_pipe #(.OUT_MODE(0), .USER_W(4), .HUE_MAX(359)) u0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0), .in_h(in_h), .in_s(in_s),
      .in_v(in_v), .in_user(in_user), .out_valid(ov0), .out_ready(out_ready), .out_rgb(rgb0),
      .out_user(ou0));
   hsv_to_rgb_pipe #(.OUT_MODE(1), .USER_W(4), .HUE_MAX(359)) u1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1), .in_h(in_h), .in_s(in_s),
      .in_v(in_v), .in_user(in_user), .out_valid(ov1), .out_ready(out_ready), .out_rgb(rgb1),
      .out_user(ou1));

   function automatic logic [23:0] ref_rgb(input int h, input int s, input int v, input int mode);
      int hc, nh, sec, rem, p, q, t, r, g, b;
      hc  = (h > 359) ? 359 : h;
      nh  = hc * 255 / 360;
      sec = nh / 43;
      rem = (nh - sec * 43) * 6;
      p   = v * (255 - s) / 256;
      q   = v * (255 - (s * rem / 256)) / 256;
      t   = v * (255 - (s * (255 - rem) / 256)) / 256;
      if (s == 0) begin r = v; g = v; b = v; end
      else if (sec == 0) begin r = v; g = t; b = p; end
      else if (sec == 1) begin r = q; g = v; b = p; end
      else if (sec == 2) begin r = p; g = v; b = t; end
      else if (sec == 3) begin r = p; g = q; b = v; end
      else if (sec == 4) begin r = t; g = p; b = v; end
      else begin r = v; g = p; b = q; end
      if (mode == 1) return {r[7:0], g[7:0], b[7:0]};
      return {8'h00, 5'(r * 31 / 255), 6'(g * 63 / 255), 5'(b * 31 / 255)};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int h, input int s, input int v, input int u);
      in_valid = 1'b1;
      in_h     = 9'(h);
      in_s     = 8'(s);
      in_v     = 8'(v);
      in_user  = 4'(u);
   endtask

   int          h4[6] = '{30, 90, 150, 210, 270, 330};
   int          s4[6] = '{200, 100, 255, 50, 180, 255};
   int          v4[6] = '{255, 180, 90, 220, 128, 60};
   logic [23:0] q0[$], q1[$];
   logic [3:0]  qu[$];

   initial begin
      int idx, got, stall, sent;
      logic acc, held;
      logic [23:0] hold_rgb, e0, e1;
      logic [3:0] hold_u, eu;
      // reset state
      #12;
      check("rst_in_ready", 32'(rdy0), 1);
      check("rst_out_valid", 32'(ov0), 0);
      check("rst_out_rgb", 32'(rgb0), 0);
      check("rst_out_user", 32'(ou0), 0);
      rst_n = 1'b1;
      step();
      // red in RGB565, latency 3
      drive(0, 255, 255, 1);
      step();
      in_valid = 1'b0;
      step();
      check("lat_not_early", 32'(ov0), 0);
      step();
      check("red565_valid", 32'(ov0), 1);
      check("red565_rgb", 32'(rgb0), 32'h00F800);
      check("red565_user", 32'(ou0), 1);
      check("red888_rgb", 32'(rgb1), 32'hFF0000);
      // back-to-back RGB888
      drive(120, 255, 255, 2);
      step();
      drive(0, 0, 128, 3);
      step();
      drive(400, 255, 255, 4);
      step();
      in_valid = 1'b0;
      check("b2b0_valid", 32'(ov1), 1);
      check("b2b0_rgb", 32'(rgb1), 32'h03FF00);
      check("b2b0_user", 32'(ou1), 2);
      step();
      check("b2b1_valid", 32'(ov1), 1);
      check("b2b1_rgb", 32'(rgb1), 32'h808080);
      check("b2b1_user", 32'(ou1), 3);
      step();
      check("b2b2_valid", 32'(ov1), 1);
      check("b2b2_rgb", 32'(rgb1), 32'hFF0015);
      check("b2b2_user", 32'(ou1), 4);
      step();
      check("b2b_empty", 32'(ov1), 0);
      // grey RGB565
      drive(200, 0, 128, 5);
      step();
      in_valid = 1'b0;
      step();
      step();
      check("grey_valid", 32'(ov0), 1);
      check("grey_rgb", 32'(rgb0), 32'h007BEF);
      step();
      // backpressure: 6 pixels, first output held for 4 cycles
      idx = 0;
      got = 0;
      stall = 0;
      for (int c = 0; c < 60 && got < 6; c++) begin
         in_valid = idx < 6;
         if (idx < 6) drive(h4[idx], s4[idx], v4[idx], 8 + idx);
         out_ready = !(ov0 && got == 0 && stall < 4);
         #1;
         held = ov0 && !out_ready;
         if (held) begin
            stall++;
            check("bp_in_ready", 32'(rdy0), 0);
            hold_rgb = rgb0;
            hold_u = ou0;
         end
         if (ov0 && out_ready) begin
            check("bp_rgb565", 32'(rgb0), 32'(ref_rgb(h4[got], s4[got], v4[got], 0)));
            check("bp_rgb888", 32'(rgb1), 32'(ref_rgb(h4[got], s4[got], v4[got], 1)));
            check("bp_user", 32'(ou0), 32'(8 + got));
            got++;
         end
         acc = in_valid && rdy0;
         step();
         if (acc) idx++;
         if (held) begin
            check("bp_hold_valid", 32'(ov0), 1);
            check("bp_hold_rgb", 32'(rgb0), 32'(hold_rgb));
            check("bp_hold_user", 32'(ou0), 32'(hold_u));
         end
      end
      check("bp_stall_cycles", 32'(stall), 4);
      check("bp_delivered", 32'(got), 6);
      check("bp_no_extra", 32'(ov0), 0);
      in_valid = 1'b0;
      out_ready = 1'b1;
      // asynchronous reset with pixels in flight
      for (int i = 0; i < 3; i++) begin
         drive(60 * i, 255, 200, i);
         step();
      end
      in_valid = 1'b0;
      check("pre_rst_valid", 32'(ov0), 1);
      rst_n = 1'b0;
      #1;
      check("rst_async_valid", 32'(ov0), 0);
      check("rst_async_rgb", 32'(rgb0), 0);
      check("rst_async_ready", 32'(rdy0), 1);
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("rst_no_stale", 32'(ov0), 0);
      end
      drive(60, 255, 255, 7);
      step();
      in_valid = 1'b0;
      step();
      check("rst_new_not_early", 32'(ov1), 0);
      step();
      check("rst_new_valid", 32'(ov1), 1);
      check("rst_new_rgb", 32'(rgb1), 32'hFFFC00);
      check("rst_new_user", 32'(ou1), 7);
      step();
      // randomised sweep with random backpressure
      sent = 0;
      for (int c = 0; c < 3000 && (sent < 200 || q0.size() > 0); c++) begin
         in_valid = sent < 200 && ($urandom_range(0, 3) != 0);
         in_h = 9'($urandom_range(0, 511));
         in_s = 8'($urandom);
         in_v = 8'($urandom);
         in_user = 4'($urandom);
         out_ready = $urandom_range(0, 3) != 0;
         #1;
         if (ov0 && out_ready) begin
            if (q0.size() == 0) check("rnd_spurious", 32'(ov0), 0);
            else begin
               e0 = q0.pop_front();
               e1 = q1.pop_front();
               eu = qu.pop_front();
               check("rnd_rgb565", 32'(rgb0), 32'(e0));
               check("rnd_rgb888", 32'(rgb1), 32'(e1));
               check("rnd_user", 32'(ou0), 32'(eu));
            end
         end
         if (in_valid && rdy0) begin
            q0.push_back(ref_rgb(int'(in_h), int'(in_s), int'(in_v), 0));
            q1.push_back(ref_rgb(int'(in_h), int'(in_s), int'(in_v), 1));
            qu.push_back(in_user);
            sent++;
         end
         step();
      end
      check("rnd_sent", 32'(sent), 200);
      check("rnd_drained", 32'(q0.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
